// File: rtl/dpram_pkg.sv
// Shared types and constants for the dual-port RAM burst master.
package dpram_pkg;

   localparam int AW_DEF = 4;
   localparam int DW_DEF = 8;
   localparam int RFD    = 4;

   typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} dpm_state_t;

endpackage

// File: rtl/dpram_rd_fifo.sv
// Small synchronous FIFO for returned read data; head is presented combinationally.
module dpram_rd_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [DW-1:0]              i_din,
   input  logic                       i_pop,
   output logic [DW-1:0]              o_dout,
   output logic [$clog2(DEPTH):0]     o_cnt,
   output logic                       o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign w_push = i_push && (r_cnt != CW'(DEPTH));
   assign w_pop  = i_pop && (r_cnt != '0);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_cnt   = r_cnt;
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/dpram_burst_master.sv
// Burst initiator for one port of the 16x8 dual-port RAM (en=1 write, en=0 registered read).
// Optional macro DPRAM_COLLIDE_CHK_EN adds a sticky same-address collision flag against the peer port.
module dpram_burst_master
   import dpram_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_wr,
   input  logic [AW-1:0] i_cmd_addr,
   input  logic [AW-1:0] i_cmd_len,
   input  logic          i_wdata_valid,
   output logic          o_wdata_ready,
   input  logic [DW-1:0] i_wdata,
   output logic          o_rdata_valid,
   input  logic          i_rdata_ready,
   output logic [DW-1:0] o_rdata,
   output logic          o_busy,
   output logic [AW-1:0] o_ram_add,
   output logic [DW-1:0] o_ram_datain,
   output logic          o_ram_en,
   input  logic [DW-1:0] i_ram_dout
`ifdef DPRAM_COLLIDE_CHK_EN
   ,
   input  logic [AW-1:0] i_peer_add,
   input  logic          i_peer_en,
   output logic          o_collide_err
`endif
);
   localparam int CW = $clog2(RFD) + 1;

   dpm_state_t    r_state;
   dpm_state_t    w_state_next;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_count;
   logic          r_p0;
   logic          r_p1;
   logic          r_alive;
   logic          r_ram_en;
   logic [AW-1:0] r_ram_add;
   logic [DW-1:0] r_ram_datain;
   logic [1:0]    w_inflight;
   logic [CW-1:0] w_fifo_cnt;
   logic          w_fifo_empty;
   logic          w_room;
   logic          w_issue;
   logic          w_cmd_fire;
   logic          w_wr_beat;
   logic          w_last;

   // r_p0/r_p1 track a read from issue edge until the RAM data reaches the FIFO
   assign w_inflight = {1'b0, r_p0} + {1'b0, r_p1};
   assign w_room     = (w_fifo_cnt + CW'(w_inflight)) < CW'(RFD);
   assign w_last     = (r_count == '0);
   assign w_cmd_fire = i_cmd_valid && o_cmd_ready;
   assign w_wr_beat  = i_wdata_valid && o_wdata_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_cmd_fire) w_state_next = i_cmd_wr ? WR : RD;
         WR:      if (w_wr_beat && w_last) w_state_next = IDLE;
         RD:      if (w_issue && w_last) w_state_next = DRAIN;
         DRAIN:   if (w_inflight == 2'd0) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // r_alive keeps cmd_ready low while reset is asserted and for the first edge after it
   always_comb begin
      o_cmd_ready   = 1'b0;
      o_wdata_ready = 1'b0;
      w_issue       = 1'b0;
      o_busy        = (r_state != IDLE);
      case (r_state)
         IDLE:    o_cmd_ready   = r_alive;
         WR:      o_wdata_ready = 1'b1;
         RD:      w_issue       = w_room;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= '0;
         r_count      <= '0;
         r_p0         <= 1'b0;
         r_p1         <= 1'b0;
         r_alive      <= 1'b0;
         r_ram_en     <= 1'b0;
         r_ram_add    <= '0;
         r_ram_datain <= '0;
      end else begin
         r_alive  <= 1'b1;
         r_p0     <= w_issue;
         r_p1     <= r_p0;
         r_ram_en <= w_wr_beat;
         if (w_cmd_fire) begin
            r_addr  <= i_cmd_addr;
            r_count <= i_cmd_len;
         end else if (w_wr_beat || w_issue) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count - 1'b1;
         end
         if (w_wr_beat) begin
            r_ram_add    <= r_addr;
            r_ram_datain <= i_wdata;
         end else if (w_issue) begin
            r_ram_add    <= r_addr;
         end
      end
   end

   assign o_ram_en     = r_ram_en;
   assign o_ram_add    = r_ram_add;
   assign o_ram_datain = r_ram_datain;

   dpram_rd_fifo #(
      .DW    (DW),
      .DEPTH (RFD)
   ) u_rd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_p1),
      .i_din   (i_ram_dout),
      .i_pop   (i_rdata_ready),
      .o_dout  (o_rdata),
      .o_cnt   (w_fifo_cnt),
      .o_empty (w_fifo_empty)
   );

   assign o_rdata_valid = !w_fifo_empty;

`ifdef DPRAM_COLLIDE_CHK_EN
   logic r_collide;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_collide <= 1'b0;
      else if (r_ram_en && i_peer_en && (r_ram_add == i_peer_add)) r_collide <= 1'b1;
   end

   assign o_collide_err = r_collide;
`endif

endmodule

// File: tb/tb_dpram_burst_master.sv
// Scoreboard bench for dpram_burst_master with a behavioural RAM and a reference memory model.
module tb_dpram_burst_master;
   import dpram_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_wr;
   logic [3:0] cmd_addr, cmd_len;
   logic       wdata_valid, wdata_ready;
   logic [7:0] wdata;
   logic       rdata_valid, rdata_ready;
   logic [7:0] rdata;
   logic       busy;
   logic [3:0] ram_add;
   logic [7:0] ram_datain;
   logic       ram_en;
   logic [7:0] ram_dout;
`ifdef DPRAM_COLLIDE_CHK_EN
   logic [3:0] peer_add;
   logic       peer_en;
   logic       collide_err;
`endif

   always #5 clk = ~clk;

   dpram_burst_master dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_wr      (cmd_wr),
      .i_cmd_addr    (cmd_addr),
      .i_cmd_len     (cmd_len),
      .i_wdata_valid (wdata_valid),
      .o_wdata_ready (wdata_ready),
      .i_wdata       (wdata),
      .o_rdata_valid (rdata_valid),
      .i_rdata_ready (rdata_ready),
      .o_rdata       (rdata),
      .o_busy        (busy),
      .o_ram_add     (ram_add),
      .o_ram_datain  (ram_datain),
      .o_ram_en      (ram_en),
      .i_ram_dout    (ram_dout)
`ifdef DPRAM_COLLIDE_CHK_EN
      ,
      .i_peer_add    (peer_add),
      .i_peer_en     (peer_en),
      .o_collide_err (collide_err)
`endif
   );

   // behavioural RAM port: en=1 writes, en=0 loads registered data_out
   logic [7:0] ram [16];
   always @(posedge clk) begin
      if (ram_en) ram[ram_add] <= ram_datain;
      else        ram_dout     <= ram[ram_add];
   end

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         n_pops   = 0;
   int         accept_cyc;
   int         rd_mode  = 0;
   int         pop_cyc [$];
   logic [7:0] ref_mem [16];
   logic [7:0] exp_rd_q [$];
   logic [11:0] exp_wr_q [$];
   logic [7:0] wq [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rd_mode)
         0:       rdata_ready = 1'b1;
         1:       rdata_ready = 1'($urandom_range(1));
         default: rdata_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // monitor: pops expectations whenever the DUT writes the RAM or hands over a read beat
   always @(negedge clk) begin
      logic [11:0] e;
      if (rst_n === 1'b1) begin
         if (ram_en) begin
            if (exp_wr_q.size() == 0) timeout("unexpected_ram_write");
            else begin
               e = exp_wr_q.pop_front();
               check("wr_addr", 32'(ram_add), 32'(e[11:8]));
               check("wr_data", 32'(ram_datain), 32'(e[7:0]));
               $display("write  addr=%0h data=%0h", ram_add, ram_datain);
            end
         end
         if (rdata_valid && rdata_ready) begin
            if (exp_rd_q.size() == 0) timeout("unexpected_rdata");
            else check("rdata", 32'(rdata), 32'(exp_rd_q.pop_front()));
            $display("read   data=%0h cyc=%0d", rdata, cyc);
            pop_cyc.push_back(cyc);
            n_pops++;
         end
      end
   end

   task automatic issue_cmd(input logic wr, input logic [3:0] addr, input logic [3:0] len,
                            output bit ok);
      int n;
      bit acc;
      n = 0;
      acc = 0;
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         n++;
      end
      cmd_valid = 1'b0;
      accept_cyc = cyc;
      ok = acc;
      if (!acc) timeout("cmd_accept");
      else $display("cmd    wr=%0d addr=%0h len=%0h", wr, addr, len);
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [3:0] len, input int gap_pct);
      bit ok;
      bit acc;
      int n;
      logic [3:0] a;
      issue_cmd(1'b1, addr, len, ok);
      if (!ok) return;
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 4'(i);
         ref_mem[a] = wq[i];
         exp_wr_q.push_back({a, wq[i]});
      end
      for (int i = 0; i <= int'(len); i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            wdata_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         wdata_valid = 1'b1;
         wdata = wq[i];
         acc = 0;
         n = 0;
         while (!acc && n < 200) begin
            @(negedge clk);
            acc = wdata_ready;
            @(posedge clk);
            #1;
            n++;
         end
         wdata_valid = 1'b0;
         if (!acc) begin
            timeout("wdata_accept");
            return;
         end
      end
   endtask

   task automatic do_read(input logic [3:0] addr, input logic [3:0] len);
      bit ok;
      logic [3:0] a;
      issue_cmd(1'b0, addr, len, ok);
      if (ok) begin
         for (int i = 0; i <= int'(len); i++) begin
            a = addr + 4'(i);
            exp_rd_q.push_back(ref_mem[a]);
         end
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_rd_q.size() != 0 || exp_wr_q.size() != 0 || busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) timeout("burst_complete");
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data(input int cnt);
      wq.delete();
      for (int i = 0; i < cnt; i++) wq.push_back(8'($urandom_range(255)));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"},   32'(cmd_ready),   0);
      check({tag, "_wdata_ready"}, 32'(wdata_ready), 0);
      check({tag, "_rdata_valid"}, 32'(rdata_valid), 0);
      check({tag, "_busy"},        32'(busy),        0);
      check({tag, "_ram_en"},      32'(ram_en),      0);
      check({tag, "_ram_add"},     32'(ram_add),     0);
      check({tag, "_ram_datain"},  32'(ram_datain),  0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      bit wr;
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
      wdata_valid = 1'b0; wdata = '0;
`ifdef DPRAM_COLLIDE_CHK_EN
      peer_add = '0; peer_en = 1'b0;
`endif
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // fill the whole RAM so every later read has a known value
      rand_data(16);
      do_write(4'h0, 4'hF, 0);
      wait_done();

      // early write data while idle must be ignored
      wdata_valid = 1'b1; wdata = 8'hEE;
      repeat (3) begin
         @(negedge clk);
         check("early_wdata_ready", 32'(wdata_ready), 0);
         @(posedge clk);
         #1;
      end
      wdata_valid = 1'b0;

      // write burst 11,22,33,44 at 2
      wq.delete();
      wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
      do_write(4'h2, 4'h3, 0);
      wait_done();
      check("ram2", 32'(ram[2]), 32'h11);
      check("ram3", 32'(ram[3]), 32'h22);
      check("ram4", 32'(ram[4]), 32'h33);
      check("ram5", 32'(ram[5]), 32'h44);

      // read back with latency and throughput checks
      rd_mode = 0;
      pop_cyc.delete();
      do_read(4'h2, 4'h3);
      base = accept_cyc;
      wait_done();
      check("rd_beats", 32'(pop_cyc.size()), 4);
      if (pop_cyc.size() == 4) begin
         check("rd_first_latency", 32'(pop_cyc[0] - base), 3);
         check("rd_back_to_back", 32'(pop_cyc[3] - pop_cyc[0]), 3);
      end

      // wrap-around write and read
      wq.delete();
      wq.push_back(8'hA1); wq.push_back(8'hB2); wq.push_back(8'hC3); wq.push_back(8'hD4);
      do_write(4'hE, 4'h3, 20);
      wait_done();
      check("ramE", 32'(ram[14]), 32'hA1);
      check("ramF", 32'(ram[15]), 32'hB2);
      check("ram0", 32'(ram[0]), 32'hC3);
      check("ram1", 32'(ram[1]), 32'hD4);
      do_read(4'hE, 4'h3);
      wait_done();

      // backpressure: issue must stall with four beats held
      rd_mode = 2;
      base = n_pops;
      do_read(4'h0, 4'hF);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("bp_rdata_valid", 32'(rdata_valid), 1);
      check("bp_busy", 32'(busy), 1);
      check("bp_last_issue_addr", 32'(ram_add), 3);
      rd_mode = 0;
      wait_done();
      check("bp_total_beats", 32'(n_pops - base), 16);

      // random traffic; sometimes commands follow without draining the FIFO
      rd_mode = 1;
      for (int t = 0; t < 40; t++) begin
         wr = 1'($urandom_range(1));
         cmd_addr = 4'($urandom_range(15));
         cmd_len = 4'($urandom_range(15));
         if (wr) begin
            rand_data(int'(cmd_len) + 1);
            do_write(cmd_addr, cmd_len, 30);
         end else begin
            do_read(cmd_addr, cmd_len);
         end
         if ($urandom_range(1) == 1) wait_done();
      end
      wait_done();

      // reset in the middle of a read burst
      rd_mode = 0;
      base = n_pops;
      do_read(4'h0, 4'hF);
      n = 0;
      while (n_pops < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) timeout("midburst_beats");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_rd_q.delete();
      exp_wr_q.delete();
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wq.delete();
      wq.push_back(8'h5A); wq.push_back(8'hA5);
      do_write(4'h9, 4'h1, 0);
      wait_done();
      do_read(4'h9, 4'h1);
      wait_done();

`ifdef DPRAM_COLLIDE_CHK_EN
      @(negedge clk);
      check("collide_clear", 32'(collide_err), 0);
      @(posedge clk);
      #1;
      peer_en = 1'b1; peer_add = 4'h7;
      wq.delete();
      wq.push_back(8'h77);
      do_write(4'h7, 4'h0, 0);
      wait_done();
      peer_en = 1'b0;
      @(negedge clk);
      check("collide_set", 32'(collide_err), 1);
      @(posedge clk);
      #1;
      wq.delete();
      wq.push_back(8'h33);
      do_write(4'h3, 4'h0, 0);
      wait_done();
      @(negedge clk);
      check("collide_sticky", 32'(collide_err), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("collide_reset", 32'(collide_err), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`endif

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
